// File: rtl/dut_pkg.sv
// Shared definitions for the 4x4 packet switch.
// Holds the fixed port count, byte width, per-input FIFO depth and the
// packet record carried through the FIFOs and output registers.
package dut_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } pkt_t;

endpackage : dut_pkg

// File: rtl/dut_top_fifo.sv
// port_fifo: per-input packet FIFO of the switch.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (clears pointers and occupancy)
//   push  - write request; ignored while full
//   din   - packet to write
//   pop   - read request from the arbiter; ignored while empty
//   dout  - packet at the head of the queue
//   empty - no packet queued
//   full  - occupancy equals depth (drives the input's ready low)
module port_fifo #(
  parameter int DEPTH = dut_pkg::FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  dut_pkg::pkt_t din,
  input  logic          pop,
  output dut_pkg::pkt_t dout,
  output logic          empty,
  output logic          full
);
  import dut_pkg::*;

  localparam int AW = $clog2(DEPTH);

  pkt_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  // Status decodes straight from the registered occupancy.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Control state: pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage: no reset needed, entries are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

endmodule : port_fifo

// File: rtl/dut_top.sv
// dut_top: 4-input / 4-output packet switch.
// Each input queues {addr, data} packets in a port_fifo; every free output
// register is loaded from one FIFO head whose addr[1:0] selects that output.
// Build option: define RR_ARB_EN for per-output round-robin arbitration;
// otherwise the lowest-index requesting input wins.
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset
//   valid_in  - per-input packet strobe
//   data_in   - per-input data byte
//   addr_in   - per-input address; [1:0] = destination, [7:2] forwarded
//   in_rdy    - per-input ready (FIFO not full)
//   valid_out - per-output packet valid
//   data_out  - per-output data byte
//   addr_out  - per-output address
//   rcv_rdy   - per-output receiver ready
module dut_top #(
  parameter int NUM_PORTS  = dut_pkg::NUM_PORTS,
  parameter int DATA_W     = dut_pkg::DATA_W,
  parameter int FIFO_DEPTH = dut_pkg::FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             valid_in,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] data_in,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] addr_in,
  output logic [NUM_PORTS-1:0]             in_rdy,
  output logic [NUM_PORTS-1:0]             valid_out,
  output logic [NUM_PORTS-1:0][DATA_W-1:0] data_out,
  output logic [NUM_PORTS-1:0][DATA_W-1:0] addr_out,
  input  logic [NUM_PORTS-1:0]             rcv_rdy
);
  import dut_pkg::*;

  localparam int PW = $clog2(NUM_PORTS);

  pkt_t                                head    [NUM_PORTS];
  logic [NUM_PORTS-1:0]                empty;
  logic [NUM_PORTS-1:0]                full;
  logic [NUM_PORTS-1:0]                pop;
  logic [NUM_PORTS-1:0]                free;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req;     // [output][input]
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt;     // [output][input], one-hot
  logic [NUM_PORTS-1:0]                gnt_any;
  pkt_t                                nxt_pkt [NUM_PORTS];
  logic [NUM_PORTS-1:0][PW-1:0]        start;

  // First requester found when scanning upward from 'start' with wrap.
  function automatic logic [NUM_PORTS-1:0] arb(input logic [NUM_PORTS-1:0] r,
                                               input logic [PW-1:0] s);
    logic [NUM_PORTS-1:0] g;
    logic                 found;
    logic [PW-1:0]        idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = s + PW'(k);
      if (!found && r[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // Input stage: one FIFO per input.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    pkt_t din;
    assign din.addr = addr_in[i];
    assign din.data = data_in[i];
    assign in_rdy[i] = !full[i];

    port_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (valid_in[i]),
      .din   (din),
      .pop   (pop[i]),
      .dout  (head[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

`ifdef RR_ARB_EN
  logic [NUM_PORTS-1:0][PW-1:0] rr_ptr;
  logic [NUM_PORTS-1:0][PW-1:0] gnt_idx;

  always_comb begin
    gnt_idx = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      start[j] = rr_ptr[j] + PW'(1);
      for (int i = 0; i < NUM_PORTS; i++)
        if (gnt[j][i]) gnt_idx[j] = PW'(i);
    end
  end

  // Pointer remembers the last granted input; it moves only on a grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= {NUM_PORTS{PW'(NUM_PORTS-1)}};
    end else begin
      for (int j = 0; j < NUM_PORTS; j++)
        if (gnt_any[j]) rr_ptr[j] <= gnt_idx[j];
    end
  end
`else
  assign start = '0;
`endif

  // Arbitration: a head requests exactly one output, so an input can never
  // be granted twice in the same cycle.
  always_comb begin
    req     = '0;
    gnt     = '0;
    gnt_any = '0;
    pop     = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      nxt_pkt[j] = '0;
      free[j]    = !valid_out[j] || rcv_rdy[j];
      for (int i = 0; i < NUM_PORTS; i++)
        req[j][i] = !empty[i] && (head[i].addr[PW-1:0] == PW'(j));
      if (free[j])
        gnt[j] = arb(req[j], start[j]);
      gnt_any[j] = |gnt[j];
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (gnt[j][i]) begin
          nxt_pkt[j] = head[i];
          pop[i]     = 1'b1;
        end
      end
    end
  end

  // Output stage: one register per output, held until the receiver takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out <= '0;
      data_out  <= '0;
      addr_out  <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (free[j]) begin
          valid_out[j] <= gnt_any[j];
          if (gnt_any[j]) begin
            data_out[j] <= nxt_pkt[j].data;
            addr_out[j] <= nxt_pkt[j].addr;
          end
        end
      end
    end
  end

endmodule : dut_top

// File: tb/tb_dut_top.sv
// Directed bench for dut_top: reset state, single packet, contention,
// fairness, backpressure, reset mid-operation and parallel routing.
module tb_dut_top;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      valid_in;
  logic [3:0][7:0] data_in;
  logic [3:0][7:0] addr_in;
  logic [3:0]      in_rdy;
  logic [3:0]      valid_out;
  logic [3:0][7:0] data_out;
  logic [3:0][7:0] addr_out;
  logic [3:0]      rcv_rdy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fair_exp [6];

  dut_top u_dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .addr_in   (addr_in),
    .in_rdy    (in_rdy),
    .valid_out (valid_out),
    .data_out  (data_out),
    .addr_out  (addr_out),
    .rcv_rdy   (rcv_rdy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef RR_ARB_EN
    fair_exp = '{8'h20, 8'h30, 8'h21, 8'h31, 8'h22, 8'h32};
`else
    fair_exp = '{8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32};
`endif
    reset    = 1'b0;
    valid_in = '0;
    data_in  = '0;
    addr_in  = '0;
    rcv_rdy  = 4'hF;

    // Reset state
    #3;
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_addr_out", 32'(addr_out), 32'h0);
    tick;
    tick;
    reset = 1'b1;
    chk("rst_in_rdy", 32'(in_rdy), 32'hF);

    // Single packet in0 -> port 2
    addr_in[0] = 8'h02;
    data_in[0] = 8'hA5;
    valid_in   = 4'b0001;
    tick;
    valid_in = '0;
    chk("single_not_yet", 32'(valid_out), 32'h0);
    tick;
    chk("single_valid", 32'(valid_out), 32'h4);
    chk("single_data", 32'(data_out[2]), 32'hA5);
    chk("single_addr", 32'(addr_out[2]), 32'h02);
    tick;
    chk("single_clear", 32'(valid_out), 32'h0);

    // Contention: all inputs -> port 1
    for (int i = 0; i < 4; i++) begin
      addr_in[i] = 8'h01;
      data_in[i] = 8'(16 + i);
    end
    valid_in = 4'hF;
    tick;
    valid_in = '0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("cont_valid", 32'(valid_out), 32'h2);
      chk("cont_data", 32'(data_out[1]), 32'(16 + k));
    end
    tick;
    chk("cont_clear", 32'(valid_out), 32'h0);

    // Fairness: in0 and in1 -> port 3, queued behind a stalled output
    rcv_rdy    = 4'b0111;
    addr_in[0] = 8'h03;
    addr_in[1] = 8'h07;
    for (int k = 0; k < 3; k++) begin
      data_in[0] = 8'(8'h20 + k);
      data_in[1] = 8'(8'h30 + k);
      valid_in   = 4'b0011;
      tick;
    end
    valid_in = '0;
    chk("fair_hold_valid", 32'(valid_out[3]), 32'h1);
    chk("fair_hold_data", 32'(data_out[3]), 32'h20);
    rcv_rdy = 4'hF;
    for (int k = 1; k < 6; k++) begin
      tick;
      chk("fair_valid", 32'(valid_out[3]), 32'h1);
      chk("fair_data", 32'(data_out[3]), 32'(fair_exp[k]));
    end
    tick;
    chk("fair_clear", 32'(valid_out), 32'h0);

    // Backpressure: in2 -> port 0 with receiver 0 stalled
    rcv_rdy    = 4'b1110;
    addr_in[2] = 8'h40;
    for (int k = 0; k < 5; k++) begin
      data_in[2] = 8'(8'h51 + k);
      valid_in   = 4'b0100;
      chk("bp_rdy_open", 32'(in_rdy[2]), 32'h1);
      tick;
    end
    chk("bp_rdy_closed", 32'(in_rdy[2]), 32'h0);
    chk("bp_hold_valid", 32'(valid_out[0]), 32'h1);
    chk("bp_hold_data", 32'(data_out[0]), 32'h51);
    chk("bp_hold_addr", 32'(addr_out[0]), 32'h40);
    data_in[2] = 8'h56;
    tick;
    tick;
    chk("bp_drop_data", 32'(data_out[0]), 32'h51);
    chk("bp_drop_rdy", 32'(in_rdy[2]), 32'h0);
    valid_in = '0;
    rcv_rdy  = 4'hF;
    for (int k = 1; k < 5; k++) begin
      tick;
      chk("bp_rel_valid", 32'(valid_out[0]), 32'h1);
      chk("bp_rel_data", 32'(data_out[0]), 32'(8'h51 + k));
    end
    tick;
    chk("bp_drained", 32'(valid_out), 32'h0);

    // Reset mid-operation
    rcv_rdy    = 4'h0;
    addr_in[1] = 8'h02;
    data_in[1] = 8'h61;
    valid_in   = 4'b0010;
    tick;
    data_in[1] = 8'h62;
    tick;
    valid_in = '0;
    tick;
    chk("mid_pre_valid", 32'(valid_out), 32'h4);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_valid_out", 32'(valid_out), 32'h0);
    chk("mid_data_out", 32'(data_out[2]), 32'h0);
    chk("mid_addr_out", 32'(addr_out[2]), 32'h0);
    tick;
    reset = 1'b1;
    chk("mid_in_rdy", 32'(in_rdy), 32'hF);
    rcv_rdy = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("mid_no_stale", 32'(valid_out), 32'h0);
    end

    // Parallel routing: in0 -> port 3, in3 -> port 0
    addr_in[0] = 8'h03;
    data_in[0] = 8'h77;
    addr_in[3] = 8'h00;
    data_in[3] = 8'h88;
    valid_in   = 4'b1001;
    tick;
    valid_in = '0;
    tick;
    chk("par_valid", 32'(valid_out), 32'h9);
    chk("par_data3", 32'(data_out[3]), 32'h77);
    chk("par_data0", 32'(data_out[0]), 32'h88);
    chk("par_addr3", 32'(addr_out[3]), 32'h03);
    chk("par_addr0", 32'(addr_out[0]), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dut_top

// File: doc/dut_top.md
DUT_TOP -- requirements
Module: dut_top

Interface
REQ-001 Parameters: NUM_PORTS, 4, input/output port count (fixed); DATA_W, 8, data and address width; FIFO_DEPTH, 4, entries per input FIFO.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 valid_in  input  [3:0]  per-input packet-valid strobe.
REQ-005 data_in  input  4x[7:0]  per-input data byte.
REQ-006 addr_in  input  4x[7:0]  per-input address; bits [1:0] are the destination port; bits [7:2] are forwarded untouched.
REQ-007 in_rdy  output  [3:0]  per-input ready; high when that input FIFO is not full.
REQ-008 valid_out  output  [3:0]  per-output packet-valid.
REQ-009 data_out  output  4x[7:0]  per-output data byte.
REQ-010 addr_out  output  4x[7:0]  per-output address, equal to the accepted addr_in.
REQ-011 rcv_rdy  input  [3:0]  per-output receiver ready.

Function
REQ-012 An input accepts a packet {addr, data} on a rising edge where valid_in[i] and in_rdy[i] are both high; valid_in while in_rdy is low is ignored (packet dropped, no state change).
REQ-013 Each input has a FIFO_DEPTH-entry FIFO; in_rdy[i] is driven from the registered occupancy (full means in_rdy low).
REQ-014 A simultaneous push and pop on a non-full FIFO are both performed and leave occupancy unchanged; a full FIFO may pop only.
REQ-015 Each output has one output register; it is free when empty or when valid_out[j] and rcv_rdy[j] are both high in the current cycle.
REQ-016 Each cycle, for every free output j, the arbiter grants one input whose non-empty FIFO head has destination j; the granted head loads into output j and is popped at the same edge.
REQ-017 An input is granted to at most one output per cycle; its head blocks that FIFO until granted (in-order per input, head-of-line blocking).
REQ-018 Latency: a packet accepted at edge N with no contention has valid_out high from edge N+1 onward.
REQ-019 valid_out, data_out and addr_out hold stable until the edge where rcv_rdy[j] is high; the output register then loads the next grant or clears valid_out.
REQ-020 The address and data bytes are passed unmodified; there is no arithmetic on the payload.

Reset
REQ-021 reset low asynchronously clears all FIFOs and pointers and sets valid_out=0, data_out=0, addr_out=0 and in_rdy=4'b1111 (after release); round-robin pointers are set to 3.
REQ-022 Reset asserted mid-transfer discards all queued and in-flight packets; no partial packet appears after release.

Configuration
REQ-023 With RR_ARB_EN defined, each output uses round-robin arbitration: search starts at (last granted input + 1) mod 4, and the pointer updates only on a grant.
REQ-024 Without RR_ARB_EN, arbitration is fixed priority: the lowest-index requesting input wins.

Structure
REQ-025 The package dut_pkg holds NUM_PORTS, DATA_W and FIFO_DEPTH, plus the typedef pkt_t {addr[7:0], data[7:0]}.
REQ-026 The per-input FIFO is the sub-module port_fifo, instantiated 4 times; arbitration and the output registers reside in dut_top.

Verification
REQ-027 Single packet: in0 sends addr=8'h02, data=8'hA5, rcv_rdy=4'hF -> valid_out[2] high one cycle after acceptance, with data_out[2]=A5 and addr_out[2]=02.
REQ-028 Contention: in0..in3 each send data 10,11,12,13 to port 1 in the same cycle, rcv_rdy=F -> out1 delivers 10,11,12,13 on consecutive cycles (RR_ARB_EN defined, or without it, since each input offers one packet).
REQ-029 Fairness: in0 and in1 stream continuously to port 3 -> with RR_ARB_EN grants alternate 0,1,0,1; without RR_ARB_EN only in0 is served while it has packets.
REQ-030 Backpressure: rcv_rdy[0]=0 while 6 packets are sent from in2 to port 0 -> out0 holds the first packet stable, in_rdy[2] drops after 5 accepted (4 queued + 1 output), and raising rcv_rdy releases them in order.
REQ-031 Reset mid-operation: pull reset low with packets queued -> valid_out=0 immediately, in_rdy=F after release, and no stale packets are emitted.
REQ-032 Parallel routing: in0->port3 and in3->port0 in the same cycle -> both outputs valid in the same cycle with correct data.
